// File: rtl/stream_checker_pkg.sv
// Shared constants, expected pattern and FSM state type for stream_checker.
package stream_checker_pkg;

  localparam int unsigned PATTERN_LEN = 4;
  localparam int unsigned PATTERN_W   = 8;
  localparam int unsigned SEL_W       = $clog2(PATTERN_LEN);

  localparam logic [PATTERN_W-1:0] PATTERN [PATTERN_LEN] = '{8'hAA, 8'h55, 8'hFF, 8'h00};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  // Expected sample for a given position within the repeating pattern.
  function automatic logic [PATTERN_W-1:0] expected_at(input logic [SEL_W-1:0] sel);
    return PATTERN[sel];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_next_c
);

  always_comb begin
    cnt_next_c = cnt;
    if (clr) begin
      cnt_next_c = '0;
    end else if (inc && (cnt != '1)) begin
      cnt_next_c = cnt + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next_c;
    end
  end

endmodule

// File: rtl/stream_checker.sv
// Checks an incoming sample stream against the repeating AA,55,FF,00 pattern.
// Optional first-mismatch capture enabled by STREAM_CHECKER_FIRST_ERR_EN.
module stream_checker
  import stream_checker_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_SAMPLES = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  err_cnt
`ifdef STREAM_CHECKER_FIRST_ERR_EN
  ,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_data
`endif
);

  // idx must be able to reach NUM_SAMPLES even when the counters are narrow.
  localparam int unsigned NS_W   = $clog2(NUM_SAMPLES + 1);
  localparam int unsigned IDX_W0 = (CNT_W > NS_W) ? CNT_W : NS_W;
  localparam int unsigned IDX_W  = (IDX_W0 > SEL_W) ? IDX_W0 : SEL_W;
  localparam int unsigned CMP_W  = (CNT_W > 32) ? CNT_W : 32;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

  chk_state_t        state;
  chk_state_t        state_next;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] exp_data_c;
  logic              accept_c;
  logic              hit_c;
  logic              last_c;
  logic              arm_c;
  logic              busy_d;
  logic              done_d;
  logic              pass_d;
  logic [CNT_W-1:0]  match_next_c;
  logic [CNT_W-1:0]  err_next_c;

  assign exp_data_c = DATA_W'(expected_at(idx[SEL_W-1:0]));
  assign accept_c   = (state == RUN) && in_valid;
  assign hit_c      = (in_data == exp_data_c);
  assign last_c     = accept_c && (idx == LAST_IDX);
  assign arm_c      = (state != RUN) && start;

  // Next state and next registered status outputs.
  always_comb begin
    state_next = state;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    pass_d     = 1'b0;
    case (state)
      IDLE:    if (start)  state_next = RUN;
      RUN:     if (last_c) state_next = DONE;
      DONE:    if (start)  state_next = RUN;
      default: state_next = IDLE;
    endcase
    busy_d = (state_next == RUN);
    done_d = (state_next == DONE);
    // Counters hold in DONE, so their next values are the final result.
    pass_d = done_d && (err_next_c == '0) &&
             (CMP_W'(match_next_c) == CMP_W'(NUM_SAMPLES));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_d;
      done  <= done_d;
      pass  <= pass_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || arm_c) begin
      idx <= '0;
    end else if (accept_c) begin
      idx <= idx + IDX_W'(1);
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr        (arm_c),
    .inc        (accept_c && hit_c),
    .cnt        (match_cnt),
    .cnt_next_c (match_next_c)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr        (arm_c),
    .inc        (accept_c && !hit_c),
    .cnt        (err_cnt),
    .cnt_next_c (err_next_c)
  );

`ifdef STREAM_CHECKER_FIRST_ERR_EN
  logic first_err_seen;

  // Capture only the first mismatch of each run.
  always_ff @(posedge clk) begin
    if (rst || arm_c) begin
      first_err_seen <= 1'b0;
      first_err_idx  <= '0;
      first_err_data <= '0;
    end else if (accept_c && !hit_c && !first_err_seen) begin
      first_err_seen <= 1'b1;
      first_err_idx  <= CNT_W'(idx);
      first_err_data <= in_data;
    end
  end
`endif

endmodule

// File: tb/tb_stream_checker.sv
// Scoreboard bench for stream_checker: three parameterisations share one stimulus bus.
module tb_stream_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;

  always #5 clk = ~clk;

  logic        busy0, done0, pass0, busy6, done6, pass6, busys, dones, passs;
  logic [15:0] m0, e0, m6, e6;
  logic [1:0]  ms, es;
`ifdef STREAM_CHECKER_FIRST_ERR_EN
  logic [15:0] fi0, fi6;
  logic [1:0]  fis;
  logic [7:0]  fd0, fd6, fds;
`endif

  stream_checker #(.DATA_W(8), .NUM_SAMPLES(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .busy(busy0), .done(done0), .pass(pass0), .match_cnt(m0), .err_cnt(e0)
`ifdef STREAM_CHECKER_FIRST_ERR_EN
    , .first_err_idx(fi0), .first_err_data(fd0)
`endif
  );

  stream_checker #(.DATA_W(8), .NUM_SAMPLES(6), .CNT_W(16)) u_dut6 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .busy(busy6), .done(done6), .pass(pass6), .match_cnt(m6), .err_cnt(e6)
`ifdef STREAM_CHECKER_FIRST_ERR_EN
    , .first_err_idx(fi6), .first_err_data(fd6)
`endif
  );

  stream_checker #(.DATA_W(8), .NUM_SAMPLES(6), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .busy(busys), .done(dones), .pass(passs), .match_cnt(ms), .err_cnt(es)
`ifdef STREAM_CHECKER_FIRST_ERR_EN
    , .first_err_idx(fis), .first_err_data(fds)
`endif
  );

  int          sel;
  logic        obs_busy, obs_done, obs_pass;
  logic [15:0] obs_match, obs_err, obs_fidx;
  logic [7:0]  obs_fdata;

  always_comb begin
    obs_busy  = busy0; obs_done = done0; obs_pass = pass0;
    obs_match = m0;    obs_err  = e0;
    obs_fidx  = '0;    obs_fdata = '0;
    case (sel)
      1: begin
        obs_busy = busy6; obs_done = done6; obs_pass = pass6;
        obs_match = m6; obs_err = e6;
      end
      2: begin
        obs_busy = busys; obs_done = dones; obs_pass = passs;
        obs_match = 16'(ms); obs_err = 16'(es);
      end
      default: ;
    endcase
`ifdef STREAM_CHECKER_FIRST_ERR_EN
    case (sel)
      1:       begin obs_fidx = fi6;       obs_fdata = fd6; end
      2:       begin obs_fidx = 16'(fis);  obs_fdata = fds; end
      default: begin obs_fidx = fi0;       obs_fdata = fd0; end
    endcase
`endif
  end

  typedef struct {
    int match;
    int err;
    bit pass;
    int fidx;
    int fdata;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] stim_q[$];
  logic [7:0] pat [4] = '{8'hAA, 8'h55, 8'hFF, 8'h00};
  int         n_total = 0;
  int         n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic feed(input logic [7:0] d);
    in_valid = 1'b1; in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  // Arms a run (with a same-cycle sample that must be ignored), plays stim_q,
  // pushes the model result, then pops and compares once done is seen.
  task automatic run_stream(input int num, input int cnt_max, input int gaps);
    exp_t e;
    bit   seen;
    int   n;
    e = '{0, 0, 1'b0, 0, 0};
    seen = 1'b0;
    n = stim_q.size();
    start = 1'b1; in_valid = 1'b1; in_data = 8'h12;
    step();
    start = 1'b0; in_valid = 1'b0;
    check("busy_after_start", 32'(obs_busy), 1);
    check("done_after_start", 32'(obs_done), 0);
    check("pass_after_start", 32'(obs_pass), 0);
    check("match_cleared", 32'(obs_match), 0);
    check("err_cleared", 32'(obs_err), 0);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (gaps) step();
      if (stim_q[i] == pat[i % 4]) begin
        if (e.match < cnt_max) e.match++;
      end else begin
        if (!seen) begin
          seen = 1'b1; e.fidx = i & cnt_max; e.fdata = int'(stim_q[i]);
        end
        if (e.err < cnt_max) e.err++;
      end
      if (i == n - 1) begin
        e.pass = (e.err == 0) && (e.match == num);
        sb_q.push_back(e);
      end
      feed(stim_q[i]);
      if (i < n - 1) check("done_early", 32'(obs_done), 0);
    end
    check("done_final", 32'(obs_done), 1);
    check("busy_drop", 32'(obs_busy), 0);
    if (obs_done === 1'b1 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("match_cnt", 32'(obs_match), 32'(e.match));
      check("err_cnt", 32'(obs_err), 32'(e.err));
      check("pass", 32'(obs_pass), 32'(e.pass));
`ifdef STREAM_CHECKER_FIRST_ERR_EN
      check("first_err_idx", 32'(obs_fidx), 32'(e.fidx));
      check("first_err_data", 32'(obs_fdata), 32'(e.fdata));
`endif
    end else begin
      check("scoreboard_drain", 32'(sb_q.size()), 0);
      sb_q.delete();
    end
  endtask

  initial begin
    sel = 0;
    do_reset();
    check("rst_busy", 32'(obs_busy), 0);
    check("rst_done", 32'(obs_done), 0);
    check("rst_pass", 32'(obs_pass), 0);
    check("rst_match", 32'(obs_match), 0);
    check("rst_err", 32'(obs_err), 0);
    check("rst_fidx", 32'(obs_fidx), 0);

    // Valid samples in IDLE are ignored.
    feed(8'hAA); feed(8'h00); step();
    check("idle_busy", 32'(obs_busy), 0);
    check("idle_match", 32'(obs_match), 0);
    check("idle_err", 32'(obs_err), 0);

    stim_q = '{8'hAA, 8'h55, 8'hFF, 8'h00};
    run_stream(4, 65535, 0);

    // Valid samples in DONE are ignored.
    feed(8'hAA); feed(8'h13); step();
    check("done_hold", 32'(obs_done), 1);
    check("done_hold_pass", 32'(obs_pass), 1);
    check("done_hold_match", 32'(obs_match), 4);
    check("done_hold_err", 32'(obs_err), 0);

    // Re-arm from DONE with one corrupted sample.
    stim_q = '{8'hAA, 8'h55, 8'hFE, 8'h00};
    run_stream(4, 65535, 0);

    // start while in RUN must not restart the run.
    start = 1'b1; step(); start = 1'b0;
    feed(8'hAA);
    start = 1'b1; step(); start = 1'b0;
    check("run_start_busy", 32'(obs_busy), 1);
    check("run_start_match", 32'(obs_match), 1);
    feed(8'h55); feed(8'hFF); feed(8'h00);
    check("run_start_done", 32'(obs_done), 1);
    check("run_start_pass", 32'(obs_pass), 1);
    check("run_start_match4", 32'(obs_match), 4);

    // Reset in the middle of a run discards the partial result.
    start = 1'b1; step(); start = 1'b0;
    feed(8'hAA); feed(8'h77);
    rst = 1'b1; step(); rst = 1'b0;
    check("midrst_busy", 32'(obs_busy), 0);
    check("midrst_done", 32'(obs_done), 0);
    check("midrst_pass", 32'(obs_pass), 0);
    check("midrst_match", 32'(obs_match), 0);
    check("midrst_err", 32'(obs_err), 0);
    check("midrst_fidx", 32'(obs_fidx), 0);
    feed(8'hAA); step();
    check("midrst_idle", 32'(obs_busy), 0);
    stim_q = '{8'hAA, 8'h55, 8'hFF, 8'h00};
    run_stream(4, 65535, 0);

    // Six-sample run with gaps; pattern wraps.
    sel = 1;
    do_reset();
    stim_q = '{8'hAA, 8'h55, 8'hFF, 8'h00, 8'hAA, 8'h55};
    run_stream(6, 65535, 2);

    // Narrow counters saturate.
    sel = 2;
    do_reset();
    stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_stream(6, 3, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
